// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the note sequencer
package seq_pkg;

    localparam int NOTE_RST = 0;
    localparam int LEN_W    = 5;
    localparam int TEMPO_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_EVT = 2'd1,
        ST_PLAY     = 2'd2
    } seq_state_t;

    // A tempo of zero would never end a unit, so it is played as one cycle per unit.
    function automatic logic [TEMPO_W-1:0] tempo_fix(input logic [TEMPO_W-1:0] tempo);
        return (tempo == '0) ? TEMPO_W'(1) : tempo;
    endfunction

endpackage

// File: rtl/seq_unit_timer.sv
// rtl/seq_unit_timer.sv - per-note cycle/unit down-timer with end-of-note and gate-off windows
module seq_unit_timer
    import seq_pkg::*;
#(
    parameter logic [31:0] GAP_CYCLES = 32'd65536
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               clear,
    input  logic               load,
    input  logic               run,
    input  logic [TEMPO_W-1:0] tempo,
    input  logic [LEN_W-1:0]   len,
    output logic               last_cycle,
    output logic               gap_window
);

    logic [TEMPO_W-1:0] cyc_cnt;
    logic [LEN_W-1:0]   unit_cnt;
    logic               unit_end;
    logic [TEMPO_W-1:0] cyc_left;

    assign unit_end = (cyc_cnt == (tempo - TEMPO_W'(1)));
    assign cyc_left = tempo - cyc_cnt;

    // Cycle counter walks 0..tempo-1 inside a unit; unit counter walks len..0 across the note.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cyc_cnt  <= '0;
            unit_cnt <= '0;
        end else if (clear) begin
            cyc_cnt  <= '0;
            unit_cnt <= '0;
        end else if (load) begin
            cyc_cnt  <= '0;
            unit_cnt <= len;
        end else if (run) begin
            if (unit_end) begin
                cyc_cnt <= '0;
                if (unit_cnt != '0) begin
                    unit_cnt <= unit_cnt - LEN_W'(1);
                end
            end else begin
                cyc_cnt <= cyc_cnt + TEMPO_W'(1);
            end
        end
    end

    // Final cycle of the note, and the trailing min(GAP_CYCLES, tempo) cycles of the last unit.
    always_comb begin
        last_cycle = run && unit_end && (unit_cnt == '0);
        gap_window = run && (unit_cnt == '0) && (cyc_left <= GAP_CYCLES);
    end

endmodule

// File: rtl/seq_event_ctrl.sv
// rtl/seq_event_ctrl.sv - note event sequencer; SEQ_GAP_EN adds a gate-off gap at each note end
module seq_event_ctrl
    import seq_pkg::*;
#(
    parameter logic [31:0] GAP_CYCLES = 32'd65536,
    parameter int          NOTE_W     = 6
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [31:0]       i_tempo,
    input  logic              i_evt_valid,
    output logic              o_evt_ready,
    input  logic [NOTE_W-1:0] i_evt_note,
    input  logic [4:0]        i_evt_len,
    input  logic              i_evt_last,
    output logic [NOTE_W-1:0] o_note,
    output logic              o_note_strobe,
    output logic              o_gate,
    output logic              o_busy,
    output logic              o_done,
    output logic [7:0]        o_underrun_cnt
);

`ifdef SEQ_GAP_EN
    localparam bit GapOn = 1'b1;
`else
    localparam bit GapOn = 1'b0;
`endif

    seq_state_t         state;
    seq_state_t         next_state;
    logic [NOTE_W-1:0]  note_q;
    logic               last_q;
    logic [TEMPO_W-1:0] tempo_q;
    logic               strobe_q;
    logic [7:0]         under_q;
    logic               accept;
    logic               play;
    logic               last_cycle;
    logic               gap_window;
    logic               starve;

    assign play   = (state == ST_PLAY);
    assign accept = i_evt_valid && o_evt_ready;
    assign starve = play && last_cycle && !last_q && !accept && !i_stop;

    seq_unit_timer #(
        .GAP_CYCLES (GAP_CYCLES)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .clear      (i_stop),
        .load       (accept),
        .run        (play),
        .tempo      (tempo_q),
        .len        (i_evt_len),
        .last_cycle (last_cycle),
        .gap_window (gap_window)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; stop overrides every other transition, including start.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    next_state = ST_WAIT_EVT;
                end
            end
            ST_WAIT_EVT: begin
                if (accept) begin
                    next_state = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (last_cycle) begin
                    if (last_q) begin
                        next_state = ST_IDLE;
                    end else if (accept) begin
                        next_state = ST_PLAY;
                    end else begin
                        next_state = ST_WAIT_EVT;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
        if (i_stop) begin
            next_state = ST_IDLE;
        end
    end

    // Handshake, gate and completion outputs decoded from state and the timer.
    always_comb begin
        o_evt_ready = 1'b0;
        o_done      = 1'b0;
        o_gate      = 1'b0;
        o_busy      = (state != ST_IDLE);
        if (!i_stop) begin
            if (state == ST_WAIT_EVT) begin
                o_evt_ready = 1'b1;
            end else if (play && last_cycle && !last_q) begin
                o_evt_ready = 1'b1;
            end
            o_done = play && last_cycle && last_q;
        end
        o_gate = play && (note_q != NOTE_W'(NOTE_RST)) && !(GapOn && gap_window);
    end

    // Event latch, note strobe and saturating underrun counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            note_q   <= '0;
            last_q   <= 1'b0;
            tempo_q  <= TEMPO_W'(1);
            strobe_q <= 1'b0;
            under_q  <= '0;
        end else begin
            strobe_q <= accept;
            if (accept) begin
                note_q  <= i_evt_note;
                last_q  <= i_evt_last;
                tempo_q <= tempo_fix(i_tempo);
            end
            if ((state == ST_IDLE) && i_start && !i_stop) begin
                under_q <= '0;
            end else if (starve && (under_q != 8'hFF)) begin
                under_q <= under_q + 8'd1;
            end
        end
    end

    assign o_note         = note_q;
    assign o_note_strobe  = strobe_q;
    assign o_underrun_cnt = under_q;

endmodule

// File: tb/tb_seq_event_ctrl.sv
// tb/tb_seq_event_ctrl.sv - scoreboard bench for seq_event_ctrl
module tb_seq_event_ctrl;

    localparam int NW  = 6;
    localparam int GAP = 2;
`ifdef SEQ_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif

    logic          i_clk       = 1'b0;
    logic          i_rst_n     = 1'b0;
    logic          i_start     = 1'b0;
    logic          i_stop      = 1'b0;
    logic [31:0]   i_tempo     = 32'd0;
    logic          i_evt_valid = 1'b0;
    logic [NW-1:0] i_evt_note  = '0;
    logic [4:0]    i_evt_len   = '0;
    logic          i_evt_last  = 1'b0;
    logic          o_evt_ready;
    logic [NW-1:0] o_note;
    logic          o_note_strobe;
    logic          o_gate;
    logic          o_busy;
    logic          o_done;
    logic [7:0]    o_underrun_cnt;

    seq_event_ctrl #(
        .GAP_CYCLES (32'd2),
        .NOTE_W     (NW)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_start        (i_start),
        .i_stop         (i_stop),
        .i_tempo        (i_tempo),
        .i_evt_valid    (i_evt_valid),
        .o_evt_ready    (o_evt_ready),
        .i_evt_note     (i_evt_note),
        .i_evt_len      (i_evt_len),
        .i_evt_last     (i_evt_last),
        .o_note         (o_note),
        .o_note_strobe  (o_note_strobe),
        .o_gate         (o_gate),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_underrun_cnt (o_underrun_cnt)
    );

    always #5 i_clk = ~i_clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    int cyc_no, n_gate, n_done, n_accept, n_busy, done_cyc;
    int strobe_cyc[$];
    bit gate_q[$];
    logic [NW-1:0] exp_q[$];

    logic [NW-1:0] ev_note[$];
    logic [4:0]    ev_len[$];
    bit            ev_last[$];
    int            ev_hold[$];

    logic          s_ready, s_gate, s_busy, s_done, s_strobe;
    logic [NW-1:0] s_note;
    logic [7:0]    s_under;

    function automatic int min_gap(input int t);
        return (GAP < t) ? GAP : t;
    endfunction

    function automatic int model_gate(input int note, input int len, input int tempo);
        int t;
        t = (tempo == 0) ? 1 : tempo;
        if (note == 0) return 0;
        return (len + 1) * t - (GAP_ON ? min_gap(t) : 0);
    endfunction

    function automatic bit model_gate_at(input int k, input int note, input int len, input int tempo);
        int t;
        t = (tempo == 0) ? 1 : tempo;
        return (note != 0) && (k < (len + 1) * t - (GAP_ON ? min_gap(t) : 0));
    endfunction

    task automatic reset_meas();
        cyc_no   = 0;
        n_gate   = 0;
        n_done   = 0;
        n_accept = 0;
        n_busy   = 0;
        done_cyc = -1;
        strobe_cyc.delete();
        gate_q.delete();
    endtask

    // One clock: sample at the falling edge, return just after the rising edge.
    task automatic step();
        logic [NW-1:0] exp_note;
        @(negedge i_clk);
        s_ready  = o_evt_ready;
        s_gate   = o_gate;
        s_busy   = o_busy;
        s_done   = o_done;
        s_strobe = o_note_strobe;
        s_note   = o_note;
        s_under  = o_underrun_cnt;
        if (s_strobe === 1'b1) begin
            strobe_cyc.push_back(cyc_no);
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL strobe_note: got note %0d, expected no strobe", s_note);
            end else begin
                exp_note = exp_q.pop_front();
                if (s_note !== exp_note) $display("FAIL strobe_note: got %0d expected %0d", s_note, exp_note);
                else pass_cnt++;
            end
        end
        gate_q.push_back(s_gate === 1'b1);
        if (s_gate === 1'b1) n_gate++;
        if (s_busy === 1'b1) n_busy++;
        if (s_done === 1'b1) begin
            n_done++;
            done_cyc = cyc_no;
        end
        if (i_evt_valid && (s_ready === 1'b1)) n_accept++;
        cyc_no++;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_start();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    // Offers queued events (each after its hold), pushes the expected note on acceptance.
    task automatic run_song(input int max_cyc, input bit must_finish);
        int  since   = 1000;
        int  n       = 0;
        bit  started = 1'b0;
        bit  ended   = 1'b0;
        while (!ended && n < max_cyc) begin
            if (ev_note.size() > 0 && since >= ev_hold[0]) begin
                i_evt_valid = 1'b1;
                i_evt_note  = ev_note[0];
                i_evt_len   = ev_len[0];
                i_evt_last  = ev_last[0];
            end else begin
                i_evt_valid = 1'b0;
            end
            step();
            n++;
            if (i_evt_valid && (s_ready === 1'b1)) begin
                exp_q.push_back(ev_note.pop_front());
                void'(ev_len.pop_front());
                void'(ev_last.pop_front());
                void'(ev_hold.pop_front());
                since   = 0;
                started = 1'b1;
            end else begin
                since++;
            end
            if (started && s_busy === 1'b0) ended = 1'b1;
        end
        i_evt_valid = 1'b0;
        if (must_finish) begin
            chk_cnt++;
            if (!ended) $display("FAIL song_timeout: no return to idle within %0d cycles", max_cyc);
            else pass_cnt++;
        end
    endtask

    task automatic add_ev(input logic [NW-1:0] note, input logic [4:0] len, input bit last, input int hold);
        ev_note.push_back(note);
        ev_len.push_back(len);
        ev_last.push_back(last);
        ev_hold.push_back(hold);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        reset_meas();
        step();
        step();
        chk_cnt++;
        if (s_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", s_busy); else pass_cnt++;
        chk_cnt++;
        if (s_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", s_ready); else pass_cnt++;
        chk_cnt++;
        if ({s_note, s_strobe, s_gate, s_done} !== '0)
            $display("FAIL reset_outputs: got note=%0d strobe=%b gate=%b done=%b expected all 0", s_note, s_strobe, s_gate, s_done);
        else pass_cnt++;
        chk_cnt++;
        if (s_under !== 8'd0) $display("FAIL reset_underrun: got %0d expected 0", s_under); else pass_cnt++;
        i_rst_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        logic [11:0] got_pat, exp_pat;
        reset_meas();
        i_tempo = 32'd4;
        do_start();
        add_ev(6'd5, 5'd1, 1'b0, 0);
        add_ev(6'd7, 5'd0, 1'b1, 0);
        run_song(100, 1'b1);
        chk_cnt++;
        if (strobe_cyc.size() != 2) $display("FAIL b2b_strobes: got %0d expected 2", strobe_cyc.size());
        else begin
            pass_cnt++;
            chk_cnt++;
            if (strobe_cyc[1] - strobe_cyc[0] != 8) $display("FAIL b2b_seamless: got spacing %0d expected 8", strobe_cyc[1] - strobe_cyc[0]);
            else pass_cnt++;
            chk_cnt++;
            if (done_cyc - strobe_cyc[0] != 11) $display("FAIL b2b_done_cycle: got %0d expected 11", done_cyc - strobe_cyc[0]);
            else pass_cnt++;
            got_pat = '0;
            exp_pat = '0;
            for (int k = 0; k < 12; k++) begin
                if (strobe_cyc[0] + k < gate_q.size()) got_pat[k] = gate_q[strobe_cyc[0] + k];
                exp_pat[k] = (k < 8) ? model_gate_at(k, 5, 1, 4) : model_gate_at(k - 8, 7, 0, 4);
            end
            chk_cnt++;
            if (got_pat !== exp_pat) $display("FAIL b2b_gate_pattern: got %b expected %b", got_pat, exp_pat);
            else pass_cnt++;
        end
        chk_cnt++;
        if (n_gate != model_gate(5, 1, 4) + model_gate(7, 0, 4))
            $display("FAIL b2b_gate_count: got %0d expected %0d", n_gate, model_gate(5, 1, 4) + model_gate(7, 0, 4));
        else pass_cnt++;
        chk_cnt++;
        if (n_done != 1) $display("FAIL b2b_done_count: got %0d expected 1", n_done); else pass_cnt++;
        chk_cnt++;
        if (s_under !== 8'd0) $display("FAIL b2b_underrun: got %0d expected 0", s_under); else pass_cnt++;
    endtask

    task automatic test_underrun();
        int low;
        reset_meas();
        i_tempo = 32'd3;
        do_start();
        add_ev(6'd9, 5'd0, 1'b0, 0);
        add_ev(6'd11, 5'd0, 1'b1, 7);
        run_song(100, 1'b1);
        chk_cnt++;
        if (s_under !== 8'd1) $display("FAIL underrun_count: got %0d expected 1", s_under); else pass_cnt++;
        chk_cnt++;
        if (strobe_cyc.size() != 2) $display("FAIL underrun_strobes: got %0d expected 2", strobe_cyc.size());
        else begin
            pass_cnt++;
            low = 0;
            for (int c = strobe_cyc[0]; c < strobe_cyc[1]; c++) if (!gate_q[c]) low++;
            chk_cnt++;
            if (low != 8 - model_gate(9, 0, 3)) $display("FAIL underrun_gate_low: got %0d expected %0d", low, 8 - model_gate(9, 0, 3));
            else pass_cnt++;
        end
        chk_cnt++;
        if (n_done != 1) $display("FAIL underrun_done: got %0d expected 1", n_done); else pass_cnt++;
        do_start();
        step();
        chk_cnt++;
        if (s_under !== 8'd0) $display("FAIL underrun_clear_on_start: got %0d expected 0", s_under); else pass_cnt++;
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
        step();
    endtask

    task automatic test_rest();
        reset_meas();
        i_tempo = 32'd2;
        do_start();
        add_ev(6'd0, 5'd2, 1'b1, 0);
        run_song(100, 1'b1);
        chk_cnt++;
        if (n_gate != 0) $display("FAIL rest_gate: got %0d high cycles expected 0", n_gate); else pass_cnt++;
        chk_cnt++;
        if (strobe_cyc.size() != 1) $display("FAIL rest_strobe: got %0d expected 1", strobe_cyc.size());
        else begin
            pass_cnt++;
            chk_cnt++;
            if (done_cyc - strobe_cyc[0] != 5) $display("FAIL rest_length: got %0d expected 5", done_cyc - strobe_cyc[0]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (n_busy != 7) $display("FAIL rest_busy: got %0d busy cycles expected 7", n_busy); else pass_cnt++;
    endtask

    task automatic test_stop();
        reset_meas();
        i_tempo = 32'd4;
        do_start();
        exp_q.push_back(6'd12);
        i_evt_valid = 1'b1;
        i_evt_note  = 6'd12;
        i_evt_len   = 5'd4;
        i_evt_last  = 1'b0;
        step();
        i_evt_note = 6'd3;
        i_evt_len  = 5'd0;
        i_evt_last = 1'b1;
        step();
        step();
        i_stop = 1'b1;
        step();
        chk_cnt++;
        if (s_ready !== 1'b0) $display("FAIL stop_ready: got %b expected 0", s_ready); else pass_cnt++;
        i_stop = 1'b0;
        step();
        chk_cnt++;
        if (s_busy !== 1'b0) $display("FAIL stop_idle: got busy %b expected 0", s_busy); else pass_cnt++;
        chk_cnt++;
        if (s_gate !== 1'b0) $display("FAIL stop_gate: got %b expected 0", s_gate); else pass_cnt++;
        repeat (3) step();
        i_evt_valid = 1'b0;
        chk_cnt++;
        if (n_accept != 1) $display("FAIL stop_consumed: got %0d acceptances expected 1", n_accept); else pass_cnt++;
        chk_cnt++;
        if (n_done != 0) $display("FAIL stop_done: got %0d expected 0", n_done); else pass_cnt++;
        chk_cnt++;
        if (exp_q.size() != 0) $display("FAIL stop_scoreboard: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_tempo_zero();
        reset_meas();
        i_tempo = 32'd0;
        do_start();
        add_ev(6'd4, 5'd3, 1'b1, 0);
        run_song(100, 1'b1);
        chk_cnt++;
        if (strobe_cyc.size() != 1 || done_cyc - strobe_cyc[0] != 3)
            $display("FAIL tempo0_length: got done offset %0d expected 3", done_cyc - (strobe_cyc.size() > 0 ? strobe_cyc[0] : 0));
        else pass_cnt++;
        chk_cnt++;
        if (n_gate != model_gate(4, 3, 0)) $display("FAIL tempo0_gate: got %0d expected %0d", n_gate, model_gate(4, 3, 0));
        else pass_cnt++;
        i_start = 1'b1;
        i_stop  = 1'b1;
        step();
        i_start = 1'b0;
        i_stop  = 1'b0;
        step();
        chk_cnt++;
        if (s_busy !== 1'b0) $display("FAIL start_stop_together: got busy %b expected 0", s_busy); else pass_cnt++;
    endtask

    task automatic test_reset_midnote();
        reset_meas();
        i_tempo = 32'd10;
        do_start();
        add_ev(6'd6, 5'd3, 1'b1, 0);
        run_song(8, 1'b0);
        i_rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (o_busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", o_busy); else pass_cnt++;
        chk_cnt++;
        if (o_gate !== 1'b0 || o_note !== '0) $display("FAIL midreset_outputs: got gate=%b note=%0d expected 0", o_gate, o_note);
        else pass_cnt++;
        step();
        step();
        chk_cnt++;
        if (n_done != 0) $display("FAIL midreset_done: got %0d expected 0", n_done); else pass_cnt++;
        i_rst_n = 1'b1;
        ev_note.delete();
        ev_len.delete();
        ev_last.delete();
        ev_hold.delete();
        step();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_underrun();
        test_rest();
        test_stop();
        test_tempo_zero();
        test_reset_midnote();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
